// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the alu_mdu execute unit: operation select codes,
// the control FSM state type and small decode helpers for the M-extension ops.
// The iterative multiply/divide datapath is only built when ALU_MDU_MULDIV_EN is defined.
package alu_mdu_pkg;

    localparam int SEL_W = 5;

    // Base (single-cycle) operation codes, sel[4] == 0
    localparam logic [3:0] ALUSEL_ADD  = 4'd0;
    localparam logic [3:0] ALUSEL_SUB  = 4'd1;
    localparam logic [3:0] ALUSEL_AND  = 4'd2;
    localparam logic [3:0] ALUSEL_OR   = 4'd3;
    localparam logic [3:0] ALUSEL_XOR  = 4'd4;
    localparam logic [3:0] ALUSEL_SLL  = 4'd5;
    localparam logic [3:0] ALUSEL_SRL  = 4'd6;
    localparam logic [3:0] ALUSEL_SRA  = 4'd7;
    localparam logic [3:0] ALUSEL_SLT  = 4'd8;
    localparam logic [3:0] ALUSEL_SLTU = 4'd9;

    // M-extension operation codes, sel[4] == 1
    localparam logic [2:0] MDSEL_MUL    = 3'd0;
    localparam logic [2:0] MDSEL_MULH   = 3'd1;
    localparam logic [2:0] MDSEL_MULHSU = 3'd2;
    localparam logic [2:0] MDSEL_MULHU  = 3'd3;
    localparam logic [2:0] MDSEL_DIV    = 3'd4;
    localparam logic [2:0] MDSEL_DIVU   = 3'd5;
    localparam logic [2:0] MDSEL_REM    = 3'd6;
    localparam logic [2:0] MDSEL_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Divide group occupies codes 4..7
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Within the divide group, REM/REMU have bit 1 set
    function automatic logic md_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // Operand A is treated as signed for MULH, MULHSU, DIV, REM
    function automatic logic md_signed_a(input logic [2:0] op);
        return (op == MDSEL_MULH) || (op == MDSEL_MULHSU) ||
               (op == MDSEL_DIV)  || (op == MDSEL_REM);
    endfunction

    // Operand B is treated as signed for MULH, DIV, REM
    function automatic logic md_signed_b(input logic [2:0] op);
        return (op == MDSEL_MULH) || (op == MDSEL_DIV) || (op == MDSEL_REM);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// mdu_iter: iterative multiply/divide datapath for alu_mdu.
// Loads operand magnitudes on start, performs one shift-add (multiply) or
// restoring-subtract (divide) step per cycle while run is high, and presents
// the sign-corrected result of the step being taken so the caller can latch
// it on the final (last) cycle. Instantiated only with ALU_MDU_MULDIV_EN.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            run,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    // hi/lo double as product {hi,lo} or {remainder, quotient/dividend}
    logic [XLEN-1:0] hi_reg, lo_reg, opnd_reg;
    logic [XLEN-1:0] hi_next, lo_next;
    logic [2:0]      op_reg;
    logic            neg_main_reg, neg_rem_reg;
    logic [CW-1:0]   count_reg;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;

    // Operand sign extraction and magnitude for the load cycle
    always_comb begin
        sign_a = md_signed_a(op) & a[XLEN-1];
        sign_b = md_signed_b(op) & b[XLEN-1];
        mag_a  = sign_a ? (~a + 1'b1) : a;
        mag_b  = sign_b ? (~b + 1'b1) : b;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shifted, div_diff;
    logic            div_fits;

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shifted = {hi_reg, lo_reg[XLEN-1]};
        div_diff    = div_shifted - {1'b0, opnd_reg};
        div_fits    = ~div_diff[XLEN];
        if (md_is_div(op_reg)) begin
            hi_next = div_fits ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], div_fits};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_raw, prod_fix;

    // Sign fix-up and result selection from the post-step values
    always_comb begin
        prod_raw = {hi_next, lo_next};
        prod_fix = neg_main_reg ? (~prod_raw + 1'b1) : prod_raw;
        result   = '0;
        case (op_reg)
            MDSEL_MUL:                           result = prod_fix[XLEN-1:0];
            MDSEL_MULH, MDSEL_MULHSU, MDSEL_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MDSEL_DIV, MDSEL_DIVU:               result = neg_main_reg ? (~lo_next + 1'b1) : lo_next;
            default:                             result = neg_rem_reg ? (~hi_next + 1'b1) : hi_next;
        endcase
    end

    assign last = (count_reg == '0);

    // Operand load on start, one datapath step and counter decrement per run cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            opnd_reg     <= '0;
            op_reg       <= MDSEL_MUL;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            count_reg    <= '0;
        end else if (start) begin
            hi_reg       <= '0;
            lo_reg       <= mag_a;
            opnd_reg     <= mag_b;
            op_reg       <= op;
            neg_main_reg <= sign_a ^ sign_b;
            neg_rem_reg  <= sign_a;
            count_reg    <= CW'(XLEN - 1);
        end else if (run) begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage arithmetic unit with valid/ready handshake.
// Holds the control FSM, the single-cycle base-op datapath and the result
// register. RV32M ops run on mdu_iter when ALU_MDU_MULDIV_EN is defined;
// otherwise every M op completes in one cycle with a zero result.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic             flush_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [XLEN-1:0]  res_o,
    output logic             busy_o
);

    localparam int              SHW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          st_reg;
    logic            valid_reg;
    logic [XLEN-1:0] res_reg;

    logic            accept;
    logic            m_start;
    logic [XLEN-1:0] m_res;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] quick_res;
    logic [XLEN-1:0] iter_res;
    logic            iter_last;
    logic [SHW-1:0]  shamt;

    assign req_ready_o = (st_reg == ST_IDLE) || ((st_reg == ST_DONE) && res_ready_i);
    assign accept      = req_valid_i && req_ready_o && !flush_i;
    assign res_valid_o = valid_reg;
    assign res_o       = res_reg;
    assign shamt       = b_i[SHW-1:0];

    // Single-cycle base operations; unknown codes yield zero
    always_comb begin
        base_res = '0;
        case (sel_i[3:0])
            ALUSEL_ADD:  base_res = a_i + b_i;
            ALUSEL_SUB:  base_res = a_i - b_i;
            ALUSEL_AND:  base_res = a_i & b_i;
            ALUSEL_OR:   base_res = a_i | b_i;
            ALUSEL_XOR:  base_res = a_i ^ b_i;
            ALUSEL_SLL:  base_res = a_i << shamt;
            ALUSEL_SRL:  base_res = a_i >> shamt;
            ALUSEL_SRA:  base_res = $unsigned($signed(a_i) >>> shamt);
            ALUSEL_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALUSEL_SLTU: base_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:     base_res = '0;
        endcase
    end

`ifdef ALU_MDU_MULDIV_EN
    logic [2:0] md_op;
    logic       div_zero, div_ovf;

    assign md_op    = sel_i[2:0];
    assign div_zero = md_is_div(md_op) && (b_i == '0);
    assign div_ovf  = md_is_div(md_op) && md_signed_a(md_op) && (a_i == MIN_VAL) && (b_i == '1);

    // Divide special cases finish at once; everything else starts the iterator
    always_comb begin
        m_start = 1'b0;
        m_res   = '0;
        if (div_zero) begin
            m_res = md_is_rem(md_op) ? a_i : '1;
        end else if (div_ovf) begin
            m_res = md_is_rem(md_op) ? '0 : MIN_VAL;
        end else begin
            m_start = sel_i[4];
        end
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && m_start),
        .run    (st_reg == ST_BUSY),
        .op     (md_op),
        .a      (a_i),
        .b      (b_i),
        .result (iter_res),
        .last   (iter_last)
    );

    assign busy_o = (st_reg == ST_BUSY);
`else
    assign m_start   = 1'b0;
    assign m_res     = '0;
    assign iter_res  = '0;
    assign iter_last = 1'b1;
    assign busy_o    = 1'b0;
`endif

    assign quick_res = sel_i[4] ? m_res : base_res;

    // Control FSM and result register; flush beats any request in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_reg    <= ST_IDLE;
            valid_reg <= 1'b0;
            res_reg   <= '0;
        end else if (flush_i) begin
            st_reg    <= ST_IDLE;
            valid_reg <= 1'b0;
        end else if (accept) begin
            if (m_start) begin
                st_reg    <= ST_BUSY;
                valid_reg <= 1'b0;
            end else begin
                st_reg    <= ST_DONE;
                valid_reg <= 1'b1;
                res_reg   <= quick_res;
            end
        end else begin
            case (st_reg)
                ST_BUSY: begin
                    if (iter_last) begin
                        st_reg    <= ST_DONE;
                        valid_reg <= 1'b1;
                        res_reg   <= iter_res;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        st_reg    <= ST_IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu (XLEN=32). Directed scenarios followed by random
// operations, all checked against an arithmetic reference model. The model
// follows the ALU_MDU_MULDIV_EN setting of the build.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  sel;
    logic [31:0] a, b;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .sel_i       (sel),
        .a_i         (a),
        .b_i         (b),
        .flush_i     (flush),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res),
        .busy_o      (busy)
    );

    // Reference result from the arithmetic definition of each operation
    function automatic logic [31:0] model(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y);
        logic [31:0]        r;
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sh;
        r  = '0;
        sp = '0;
        up = '0;
        sh = int'(y[4:0]);
        if (!s[4]) begin
            case (s[3:0])
                ALUSEL_ADD:  r = x + y;
                ALUSEL_SUB:  r = x - y;
                ALUSEL_AND:  r = x & y;
                ALUSEL_OR:   r = x | y;
                ALUSEL_XOR:  r = x ^ y;
                ALUSEL_SLL:  r = x << sh;
                ALUSEL_SRL:  r = x >> sh;
                ALUSEL_SRA:  begin sp = longint'($signed(x)) >>> sh; r = sp[31:0]; end
                ALUSEL_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                ALUSEL_SLTU: r = (x < y) ? 32'd1 : 32'd0;
                default:     r = '0;
            endcase
        end
`ifdef ALU_MDU_MULDIV_EN
        else begin
            case (s[2:0])
                MDSEL_MUL:    begin up = {32'b0, x} * {32'b0, y}; r = up[31:0]; end
                MDSEL_MULH:   begin sp = longint'($signed(x)) * longint'($signed(y)); r = sp[63:32]; end
                MDSEL_MULHSU: begin sp = longint'($signed(x)) * $signed({32'b0, y}); r = sp[63:32]; end
                MDSEL_MULHU:  begin up = {32'b0, x} * {32'b0, y}; r = up[63:32]; end
                MDSEL_DIV: begin
                    if (y == 32'd0)                        r = 32'hFFFF_FFFF;
                    else if (x == MIN32 && y == 32'hFFFF_FFFF) r = MIN32;
                    else                                   r = $signed(x) / $signed(y);
                end
                MDSEL_DIVU: begin
                    if (y == 32'd0) r = 32'hFFFF_FFFF;
                    else            r = x / y;
                end
                MDSEL_REM: begin
                    if (y == 32'd0)                        r = x;
                    else if (x == MIN32 && y == 32'hFFFF_FFFF) r = 32'd0;
                    else                                   r = $signed(x) % $signed(y);
                end
                default: begin
                    if (y == 32'd0) r = x;
                    else            r = x % y;
                end
            endcase
        end
`endif
        return r;
    endfunction

    // Reference latency: iterative M ops take XLEN+1 cycles, all else 1
    function automatic int model_lat(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y);
        int  lat;
        logic is_div, is_sdiv;
        lat = 1;
        is_div  = (s[2:0] == MDSEL_DIV) || (s[2:0] == MDSEL_DIVU) ||
                  (s[2:0] == MDSEL_REM) || (s[2:0] == MDSEL_REMU);
        is_sdiv = (s[2:0] == MDSEL_DIV) || (s[2:0] == MDSEL_REM);
`ifdef ALU_MDU_MULDIV_EN
        if (s[4]) begin
            if (is_div && y == 32'd0)                                 lat = 1;
            else if (is_sdiv && x == MIN32 && y == 32'hFFFF_FFFF)      lat = 1;
            else                                                      lat = 33;
        end
`else
        if (is_div && is_sdiv && x == y) lat = 1;
`endif
        return lat;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: issue, wait for result, check, consume
    task automatic run_op(input logic [4:0] s, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] e;
        int          el, cyc;
        e  = model(s, x, y);
        el = model_lat(s, x, y);
        sel = s; a = x; b = y;
        req_valid = 1'b1;
        res_ready = 1'b0;
        check({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        sel = 5'($urandom);
        a   = $urandom;
        b   = $urandom;
        check({tag, "_busy"}, {31'b0, busy}, (el > 1) ? 32'd1 : 32'd0);
        cyc = 1;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(el));
        check({tag, "_res"}, res, e);
        $display("op %s sel=%h a=%h b=%h res=%h lat=%0d", tag, s, x, y, res, cyc);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] e1, e2, held;
        logic        seen;
        logic [4:0]  rs;
        logic [31:0] rx, ry;
        int          mode;

        rst = 1'b0; req_valid = 1'b0; sel = '0; a = '0; b = '0;
        flush = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'b0, res_valid}, 32'd0);
        check("reset_res",   res, 32'd0);
        check("reset_busy",  {31'b0, busy}, 32'd0);
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a divide
        sel = {2'b10, MDSEL_DIV}; a = 32'd1000; b = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", {31'b0, res_valid}, 32'd0);
        check("midrst_busy",  {31'b0, busy}, 32'd0);
        check("midrst_ready", {31'b0, req_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back SRA then SLT
        e1 = model({1'b0, ALUSEL_SRA}, MIN32, 32'd4);
        e2 = model({1'b0, ALUSEL_SLT}, 32'hFFFF_FFFF, 32'd1);
        sel = {1'b0, ALUSEL_SRA}; a = MIN32; b = 32'd4;
        req_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_sra_valid", {31'b0, res_valid}, 32'd1);
        check("b2b_sra_res", res, e1);
        check("b2b_sra_const", res, 32'hF800_0000);
        check("b2b_ready", {31'b0, req_ready}, 32'd1);
        sel = {1'b0, ALUSEL_SLT}; a = 32'hFFFF_FFFF; b = 32'd1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_slt_valid", {31'b0, res_valid}, 32'd1);
        check("b2b_slt_res", res, e2);
        $display("op b2b sra=%h slt=%h", e1, res);
        req_valid = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;

        // Directed M-op and special cases
        run_op({2'b10, MDSEL_MULH},   MIN32,          MIN32,          "mulh_min");
        run_op({2'b10, MDSEL_MULHSU}, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulhsu_m1");
        run_op({2'b10, MDSEL_DIV},    32'hFFFF_FFF9,  32'd2,          "div_m7_2");
        run_op({2'b10, MDSEL_REM},    32'hFFFF_FFF9,  32'd2,          "rem_m7_2");
        run_op({2'b10, MDSEL_DIVU},   32'd7,          32'd0,          "divu_zero");
        run_op({2'b10, MDSEL_REMU},   32'd7,          32'd0,          "remu_zero");
        run_op({2'b10, MDSEL_DIV},    MIN32,          32'hFFFF_FFFF,  "div_ovf");
        run_op({2'b10, MDSEL_REM},    MIN32,          32'hFFFF_FFFF,  "rem_ovf");
        run_op({2'b10, MDSEL_MUL},    32'd12345,      32'hFFFF_FFFE,  "mul_neg");
        run_op({1'b0, 4'd13},         32'h1234_5678,  32'h9ABC_DEF0,  "undef_sel");

        // Result held while the consumer stalls
        e1 = model({1'b0, ALUSEL_ADD}, 32'hFFFF_FFF0, 32'h0000_0020);
        sel = {1'b0, ALUSEL_ADD}; a = 32'hFFFF_FFF0; b = 32'h0000_0020;
        req_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        held = res;
        for (int i = 0; i < 5; i++) begin
            check("stall_res", res, e1);
            check("stall_valid", {31'b0, res_valid}, 32'd1);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check("stall_stable", res, held);
        $display("op stall add res=%h", res);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Flush with a same-cycle request: request must not be accepted
        sel = {1'b0, ALUSEL_ADD}; a = 32'd1; b = 32'd2;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("flushreq_valid", {31'b0, res_valid}, 32'd0);
        check("flushreq_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flushreq_after", {31'b0, res_valid}, 32'd0);
        $display("op flush_with_request valid=%0d", res_valid);

        // Flush right after issuing a divide: no result may appear
        sel = {2'b10, MDSEL_DIV}; a = 32'd100; b = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | res_valid;
            @(negedge clk);
        end
        check("flushbusy_noresult", {31'b0, seen}, 32'd0);
        check("flushbusy_busy", {31'b0, busy}, 32'd0);
        check("flushbusy_ready", {31'b0, req_ready}, 32'd1);
        $display("op flush_in_busy seen=%0d", seen);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) rs = {2'b10, 3'($urandom_range(0, 7))};
            else                           rs = {1'b0, 4'($urandom_range(0, 15))};
            rx = $urandom;
            ry = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) ry = 32'd0;
            if (mode == 1) begin rx = MIN32; ry = 32'hFFFF_FFFF; end
            if (mode == 2) ry = 32'(ry[7:0]);
            run_op(rs, rx, ry, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
